// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path constants for the fetch unit and ControlUnitMIPS: opcodes, pc_src commands, stall counter.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_JL    = 6'd1;
  localparam logic [5:0] OP_JR    = 6'd2;
  localparam logic [5:0] OP_EXM   = 6'd3;
  localparam logic [5:0] OP_EXR   = 6'd4;
  localparam logic [5:0] NOP_OP   = 6'h3F;

  localparam logic [1:0] PC_SRC_NEXT = 2'b00;
  localparam logic [1:0] PC_SRC_HOLD = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;
  localparam logic [1:0] PC_SRC_JREG = 2'b11;

  localparam int         STALL_W   = 8;
  localparam logic [7:0] STALL_MAX = 8'd255;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: increment, hold, pseudo-direct jump (pc_id upper bits + 26-bit index) or register target.
// Combinational, zero latency; no flow control. Unknown pc_src holds the PC.
module pc_next_sel
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      pc_src,
  input  logic [PC_W-1:0] pc,
  input  logic [25:0]     jump_index,
  input  logic [PC_W-1:0] pc_id,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] pc_next
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] jump_tgt;

  always_comb begin
    // Pure bit replacement of the low 26 bits: no carry into the region taken from pc_id.
    jump_tgt        = pc_id;
    jump_tgt[25:0]  = jump_index;
    pc_next         = pc;
    case (pc_src)
      PC_SRC_NEXT: pc_next = pc + PC_ONE;
      PC_SRC_HOLD: pc_next = pc;
      PC_SRC_JUMP: pc_next = jump_tgt;
      PC_SRC_JREG: pc_next = jr_target;
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC and IF/ID instruction registers; fetch-to-decode latency 2 edges, jumps flush both stages (2 bubbles).
// Backpressure: pc_src=01 freezes the whole front end and counts stall cycles (saturating).
module instr_fetch_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'hFC00_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [5:0]      ctrl_instr,
  output logic [5:0]      func,
  output logic [5:0]      ctrl_instr_if,
  output logic [5:0]      ctrl_instr_if1,
  output logic [PC_W-1:0] pc_id,
  output logic [PC_W-1:0] link_addr,
  output logic [7:0]      stall_cnt
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_if;
  logic [PC_W-1:0] pc_next;
  logic [31:0]     if_reg;
  logic [31:0]     id_reg;
  logic [5:0]      if_op_prev;
  logic [7:0]      stall_sat;

  pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .pc_src     (pc_src),
    .pc         (pc),
    .jump_index (id_reg[25:0]),
    .pc_id      (pc_id),
    .jr_target  (jr_target),
    .pc_next    (pc_next)
  );

  assign stall_sat = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pc_if      <= '0;
      pc_id      <= '0;
      if_reg     <= NOP_INSTR;
      id_reg     <= NOP_INSTR;
      if_op_prev <= NOP_OP;
      stall_cnt  <= '0;
    end else begin
      pc <= pc_next;
      case (pc_src)
        PC_SRC_NEXT: begin
          if_reg     <= imem_rdata;
          pc_if      <= pc;
          id_reg     <= if_reg;
          pc_id      <= pc_if;
          if_op_prev <= opcode_of(if_reg);
          stall_cnt  <= '0;
        end
        PC_SRC_HOLD: begin
          stall_cnt <= stall_sat;
        end
        PC_SRC_JUMP, PC_SRC_JREG: begin
          // pc_id is left alone so the link address seen at the jump edge stays coherent.
          if_reg     <= NOP_INSTR;
          id_reg     <= NOP_INSTR;
          if_op_prev <= opcode_of(if_reg);
          stall_cnt  <= '0;
        end
        default: begin
          stall_cnt <= stall_sat;
        end
      endcase
    end
  end

  assign imem_addr      = pc;
  assign ctrl_instr     = opcode_of(id_reg);
  assign func           = id_reg[5:0];
  assign ctrl_instr_if  = opcode_of(if_reg);
  assign ctrl_instr_if1 = if_op_prev;
  assign link_addr      = pc_id + PC_ONE;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: small ROM model, scenario tasks with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [5:0]  ctrl_instr;
  logic [5:0]  func;
  logic [5:0]  ctrl_instr_if;
  logic [5:0]  ctrl_instr_if1;
  logic [31:0] pc_id;
  logic [31:0] link_addr;
  logic [7:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_src         (pc_src),
    .jr_target      (jr_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ctrl_instr     (ctrl_instr),
    .func           (func),
    .ctrl_instr_if  (ctrl_instr_if),
    .ctrl_instr_if1 (ctrl_instr_if1),
    .pc_id          (pc_id),
    .link_addr      (link_addr),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_rdata = 32'h0022_1800;  // Rtype add
      32'h0000_0001: imem_rdata = 32'h0022_1801;  // Rtype or
      32'h0000_0002: imem_rdata = 32'h1000_0000;  // Exr
      32'h0000_0003: imem_rdata = 32'h0C00_0000;  // Exm
      32'h0000_0004: imem_rdata = 32'h0000_0005;
      32'h0000_0005: imem_rdata = 32'h0400_0040;  // JL 0x40
      32'h0000_0006: imem_rdata = 32'h1400_0006;
      32'h0000_0040: imem_rdata = 32'h0800_0000;  // Jr
      32'h0000_1234: imem_rdata = 32'h1000_0ABC;
      default:       imem_rdata = 32'h0000_0007;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_src = 2'b00; jr_target = '0;
    #1;
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'd0); end
    n_checks++; if (ctrl_instr !== 6'h3F) begin n_fail++; $display("FAIL reset_ctrl_instr got %b exp %b", ctrl_instr, 6'h3F); end
    n_checks++; if (ctrl_instr_if1 !== 6'h3F) begin n_fail++; $display("FAIL reset_if1 got %b exp %b", ctrl_instr_if1, 6'h3F); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
    n_checks++; if (link_addr !== 32'd1) begin n_fail++; $display("FAIL reset_link got %h exp 1", link_addr); end
    #6 rst = 1'b0;
  endtask

  task automatic test_advance();
    pc_src = 2'b00;
    step();
    n_checks++; if (imem_addr !== 32'd1) begin n_fail++; $display("FAIL adv1_pc got %h exp 1", imem_addr); end
    n_checks++; if (ctrl_instr !== 6'h3F) begin n_fail++; $display("FAIL adv1_id_bubble got %b exp 111111", ctrl_instr); end
    step();
    n_checks++; if (imem_addr !== 32'd2) begin n_fail++; $display("FAIL adv2_pc got %h exp 2", imem_addr); end
    n_checks++; if (ctrl_instr !== 6'b000000) begin n_fail++; $display("FAIL adv2_ctrl got %b exp 000000", ctrl_instr); end
    n_checks++; if (func !== 6'b000000) begin n_fail++; $display("FAIL adv2_func got %b exp 000000", func); end
    step();
    n_checks++; if (imem_addr !== 32'd3) begin n_fail++; $display("FAIL adv3_pc got %h exp 3", imem_addr); end
    n_checks++; if (func !== 6'b000001) begin n_fail++; $display("FAIL adv3_func got %b exp 000001", func); end
    n_checks++; if (pc_id !== 32'd1) begin n_fail++; $display("FAIL adv3_pc_id got %h exp 1", pc_id); end
  endtask

  task automatic test_stall();
    step();  // Exm reaches IF, Exr becomes the older IF opcode
    n_checks++; if (ctrl_instr_if !== 6'b000011) begin n_fail++; $display("FAIL stall_pre_if got %b exp 000011", ctrl_instr_if); end
    pc_src = 2'b01;
    for (int i = 1; i <= 2; i++) begin
      step();
      n_checks++; if (imem_addr !== 32'd4) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 4", i, imem_addr); end
      n_checks++; if (ctrl_instr_if !== 6'b000011) begin n_fail++; $display("FAIL stall_if[%0d] got %b exp 000011", i, ctrl_instr_if); end
      n_checks++; if (ctrl_instr_if1 !== 6'b000100) begin n_fail++; $display("FAIL stall_if1[%0d] got %b exp 000100", i, ctrl_instr_if1); end
      n_checks++; if (ctrl_instr !== 6'b000100) begin n_fail++; $display("FAIL stall_id[%0d] got %b exp 000100", i, ctrl_instr); end
      n_checks++; if (stall_cnt !== 8'(i)) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, stall_cnt, i); end
    end
    pc_src = 2'b00;
    step();
    n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL stall_clear got %0d exp 0", stall_cnt); end
    n_checks++; if (imem_addr !== 32'd5) begin n_fail++; $display("FAIL stall_release_pc got %h exp 5", imem_addr); end
    n_checks++; if (ctrl_instr !== 6'b000011) begin n_fail++; $display("FAIL stall_release_id got %b exp 000011", ctrl_instr); end
  endtask

  task automatic test_jump();
    step();
    step();  // JL now in ID with pc_id=5
    n_checks++; if (ctrl_instr !== 6'b000001) begin n_fail++; $display("FAIL jl_in_id got %b exp 000001", ctrl_instr); end
    n_checks++; if (pc_id !== 32'd5) begin n_fail++; $display("FAIL jl_pc_id got %h exp 5", pc_id); end
    n_checks++; if (link_addr !== 32'd6) begin n_fail++; $display("FAIL jl_link got %h exp 6", link_addr); end
    pc_src = 2'b10;
    step();
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL jl_target got %h exp 40", imem_addr); end
    n_checks++; if (ctrl_instr !== 6'h3F) begin n_fail++; $display("FAIL jl_flush_id got %b exp 111111", ctrl_instr); end
    n_checks++; if (ctrl_instr_if !== 6'h3F) begin n_fail++; $display("FAIL jl_flush_if got %b exp 111111", ctrl_instr_if); end
    n_checks++; if (ctrl_instr_if1 !== 6'b000101) begin n_fail++; $display("FAIL jl_if1 got %b exp 000101", ctrl_instr_if1); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL jl_stall got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_jr();
    pc_src = 2'b00;
    step();
    n_checks++; if (ctrl_instr !== 6'h3F) begin n_fail++; $display("FAIL jl_bubble2 got %b exp 111111", ctrl_instr); end
    step();
    n_checks++; if (ctrl_instr !== 6'b000010) begin n_fail++; $display("FAIL jr_in_id got %b exp 000010", ctrl_instr); end
    jr_target = 32'h1234; pc_src = 2'b11;
    step();
    n_checks++; if (imem_addr !== 32'h1234) begin n_fail++; $display("FAIL jr_target got %h exp 1234", imem_addr); end
    n_checks++; if (ctrl_instr !== 6'h3F) begin n_fail++; $display("FAIL jr_flush_id got %b exp 111111", ctrl_instr); end
    n_checks++; if (ctrl_instr_if !== 6'h3F) begin n_fail++; $display("FAIL jr_flush_if got %b exp 111111", ctrl_instr_if); end
    pc_src = 2'b00;
    step();
    step();
    n_checks++; if (ctrl_instr !== 6'b000100) begin n_fail++; $display("FAIL jr_reach_id got %b exp 000100", ctrl_instr); end
    n_checks++; if (func !== 6'h3C) begin n_fail++; $display("FAIL jr_reach_func got %h exp 3c", func); end
    n_checks++; if (pc_id !== 32'h1234) begin n_fail++; $display("FAIL jr_reach_pc_id got %h exp 1234", pc_id); end
  endtask

  task automatic test_wrap_saturate();
    jr_target = 32'hFFFF_FFFF; pc_src = 2'b11;
    step();
    n_checks++; if (imem_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_setup got %h exp ffffffff", imem_addr); end
    pc_src = 2'b00;
    step();
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", imem_addr); end
    step();
    pc_src = 2'b01;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254 || i == 255 || i == 300) begin
        n_checks++;
        if (stall_cnt !== ((i < 255) ? 8'(i) : 8'd255)) begin
          n_fail++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt, (i < 255) ? i : 255);
        end
      end
    end
    n_checks++; if (imem_addr !== 32'd1) begin n_fail++; $display("FAIL sat_pc_hold got %h exp 1", imem_addr); end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL arst_pc got %h exp 0", imem_addr); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_stall got %0d exp 0", stall_cnt); end
    n_checks++; if (ctrl_instr !== 6'h3F) begin n_fail++; $display("FAIL arst_id got %b exp 111111", ctrl_instr); end
    n_checks++; if (ctrl_instr_if !== 6'h3F) begin n_fail++; $display("FAIL arst_if got %b exp 111111", ctrl_instr_if); end
    n_checks++; if (pc_id !== 32'd0) begin n_fail++; $display("FAIL arst_pc_id got %h exp 0", pc_id); end
    #2 rst = 1'b0;
    pc_src = 2'b00;
    step();
    n_checks++; if (imem_addr !== 32'd1) begin n_fail++; $display("FAIL arst_resume got %h exp 1", imem_addr); end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_stall();
    test_jump();
    test_jr();
    test_wrap_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
